// File: rtl/pixmem_pkg.sv
// Shared definitions for the pixel window responder.
//   state_t        : responder FSM encoding (3 bits)
//   WIN_LEFT/CTR/RIGHT : pixel slot indices inside rd_window (slot * PIX_W
//                    gives the LSB of that pixel; left sits in the MSBs)
//   addr_in_range  : address bounds check against the configured row depth
package pixmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_F3   = 3'd4,
    ST_RESP = 3'd5,
    ST_WR   = 3'd6
  } state_t;

  localparam int WIN_LEFT  = 2;
  localparam int WIN_CTR   = 1;
  localparam int WIN_RIGHT = 0;

  // Both operands are widened to 32 bits by the caller so that a depth equal
  // to 2**ADDR_W still compares correctly.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Single-port pixel row storage.
//   clk   : clock, all activity on posedge
//   we    : write enable; mem[addr] <= wdata at the edge
//   re    : read enable; rdata <= mem[addr] at the edge (1-cycle latency)
//   addr  : shared read/write address, caller keeps it below DEPTH
//   wdata : write data
//   rdata : registered read data, holds when re is low
module pixel_ram #(
  parameter int PIX_W  = 1,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pixel_window_responder.sv
// Memory-side responder for the salt-and-pepper filter controller.
// Serves {left, centre, right} read windows, accepts filtered write-backs and
// lets a host preload the row while the responder is idle.
//   clk, rst          : clock and synchronous active-high reset
//   ld_en/addr/data   : host preload port, honoured only in IDLE
//   rd_req/addr       : window request; rd_ack pulses with rd_window valid
//   wr_req/addr/data  : write-back request; wr_ack pulses in the commit cycle
//   busy              : high whenever the FSM is not in IDLE
//   err               : sticky out-of-range flag, cleared only by rst
//
// Handshake: a requester raises req with address/data stable and holds it
// until the matching ack pulse; it must drop req in the ack cycle so that the
// following IDLE cycle does not see a fresh request. The block latches all
// request fields at the sampling edge, and rd_ack / wr_ack are never high in
// the same cycle because they decode from distinct FSM states.
module pixel_window_responder
  import pixmem_pkg::*;
#(
  parameter int PIX_W  = 1,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [PIX_W-1:0]   ld_data,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic [3*PIX_W-1:0] rd_window,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  output logic               wr_ack,
  output logic               busy,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t             state;
  logic [ADDR_W-1:0]  a_q;         // latched centre address
  logic               rd_oor;      // latched read address was out of range
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic               wr_ok_q;
  logic [PIX_W-1:0]   cap_l;
  logic [PIX_W-1:0]   cap_c;

  logic               ld_ok;
  logic               wr_ok;
  logic               rd_ok;
  logic [ADDR_W-1:0]  l_addr;
  logic [ADDR_W-1:0]  r_addr;
  logic [3*PIX_W-1:0] window_next;

  logic               ram_we;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [PIX_W-1:0]   ram_wdata;
  logic [PIX_W-1:0]   ram_rdata;

  assign ld_ok = addr_in_range(32'(ld_addr), 32'(DEPTH));
  assign wr_ok = addr_in_range(32'(wr_addr), 32'(DEPTH));
  assign rd_ok = addr_in_range(32'(rd_addr), 32'(DEPTH));

  // Row edges replicate the edge pixel instead of wrapping.
  assign l_addr = (a_q == '0)        ? '0        : a_q - ADDR_W'(1);
  assign r_addr = (a_q == LAST_ADDR) ? LAST_ADDR : a_q + ADDR_W'(1);

  assign rd_ack = (state == ST_RESP);
  assign wr_ack = (state == ST_WR);
  assign busy   = (state != ST_IDLE);

  // RAM port arbitration. The FSM only ever occupies one path per cycle, so
  // the state alone selects between load, write-back and fetch. Writes are
  // gated by rst so a reset edge never commits a pending write.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = ld_data;
    case (state)
      ST_IDLE: begin
        ram_addr = ld_addr;
        ram_we   = ld_en && ld_ok && !rst;
      end
      ST_WR: begin
        ram_addr  = wr_addr_q;
        ram_wdata = wr_data_q;
        ram_we    = wr_ok_q && !rst;
      end
      ST_F0: begin
        ram_addr = l_addr;
        ram_re   = !rd_oor;
      end
      ST_F1: begin
        ram_addr = a_q;
        ram_re   = !rd_oor;
      end
      ST_F2: begin
        ram_addr = r_addr;
        ram_re   = !rd_oor;
      end
      default: begin
      end
    endcase
  end

  // In F3 the right pixel is still on the RAM output, so the window is
  // assembled from the two captured pixels plus the live read data.
  always_comb begin
    window_next = '0;
    if (!rd_oor) begin
      window_next[WIN_LEFT*PIX_W  +: PIX_W] = cap_l;
      window_next[WIN_CTR*PIX_W   +: PIX_W] = cap_c;
      window_next[WIN_RIGHT*PIX_W +: PIX_W] = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err       <= 1'b0;
      rd_window <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_en) begin
            if (!ld_ok) begin
              err <= 1'b1;
            end
          end else if (wr_req) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
            wr_ok_q   <= wr_ok;
            if (!wr_ok) begin
              err <= 1'b1;
            end
            state <= ST_WR;
          end else if (rd_req) begin
            a_q    <= rd_addr;
            rd_oor <= !rd_ok;
            if (!rd_ok) begin
              err <= 1'b1;
            end
            state <= ST_F0;
          end
        end
        ST_F0: state <= ST_F1;
        ST_F1: begin
          cap_l <= ram_rdata;
          state <= ST_F2;
        end
        ST_F2: begin
          cap_c <= ram_rdata;
          state <= ST_F3;
        end
        ST_F3: begin
          rd_window <= window_next;
          state     <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        ST_WR:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  pixel_ram #(
    .PIX_W  (PIX_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_pixel_window_responder.sv
// Bench for pixel_window_responder. Two instances share every input: one with
// the full 64-pixel row and one configured for a 48-pixel row, so addresses
// 48..63 exercise the out-of-range behaviour while the same stimulus is
// checked in range on the other instance.
module tb_pixel_window_responder;

  logic       clk;
  logic       rst;
  logic       ld_en;
  logic [5:0] ld_addr;
  logic       ld_data;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic       wr_req;
  logic [5:0] wr_addr;
  logic       wr_data;

  logic       rd_ack, wr_ack, busy, err;
  logic [2:0] rd_window;
  logic       rd_ack_b, wr_ack_b, busy_b, err_b;
  logic [2:0] rd_window_b;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic mem64 [64];
  logic mem48 [64];
  logic err64_m, err48_m;
  logic [2:0] win64_m, win48_m;

  pixel_window_responder #(.PIX_W(1), .DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_window(rd_window),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .err(err)
  );

  pixel_window_responder #(.PIX_W(1), .DEPTH(48), .ADDR_W(6)) dut48 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack_b), .rd_window(rd_window_b),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_b),
    .busy(busy_b), .err(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window rule from the row definition: neighbours clamp at the row ends,
  // out-of-range centres return all zeros.
  function automatic logic [2:0] exp_win(input int depth, input int a, input bit use48);
    int l, r;
    if (a >= depth) return 3'b000;
    l = (a == 0) ? 0 : a - 1;
    r = (a == depth - 1) ? depth - 1 : a + 1;
    if (use48) return {mem48[l], mem48[a], mem48[r]};
    return {mem64[l], mem64[a], mem64[r]};
  endfunction

  task automatic check_err();
    check("err64", err, err64_m);
    check("err48", err_b, err48_m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_en = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    err64_m = 1'b0; err48_m = 1'b0;
    win64_m = 3'b000; win48_m = 3'b000;
  endtask

  // Waits (bounded) for the requested ack; returns the number of negedges.
  task automatic wait_ack(input bit want_rd, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((want_rd ? rd_ack : wr_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("ack_seen", 32'(lat != 0), 1);
    check("peer_ack", 32'(want_rd ? rd_ack_b : wr_ack_b), 1);
    check("ack_exclusive", 32'(want_rd ? wr_ack : rd_ack), 0);
    check("busy_at_ack", busy, 1);
  endtask

  task automatic do_load(input int a, input logic d);
    ld_addr = 6'(a); ld_data = d; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    mem64[a] = d;
    if (a < 48) mem48[a] = d;
    else err48_m = 1'b1;
    check_err();
  endtask

  task automatic check_window(input int a);
    win64_m = exp_win(64, a, 1'b0);
    win48_m = exp_win(48, a, 1'b1);
    check("win64", rd_window, win64_m);
    check("win48", rd_window_b, win48_m);
  endtask

  task automatic do_read(input int a);
    int lat;
    rd_addr = 6'(a); rd_req = 1'b1;
    wait_ack(1'b1, lat);
    rd_req = 1'b0;
    if (a >= 48) err48_m = 1'b1;
    check("rd_latency", lat, 5);
    check_window(a);
    check_err();
    @(negedge clk);
    check("rd_ack_pulse", rd_ack, 0);
    check("win64_hold", rd_window, win64_m);
    check("win48_hold", rd_window_b, win48_m);
  endtask

  task automatic do_write(input int a, input logic d);
    int lat;
    wr_addr = 6'(a); wr_data = d; wr_req = 1'b1;
    wait_ack(1'b0, lat);
    wr_req = 1'b0;
    check("wr_latency", lat, 1);
    mem64[a] = d;
    if (a < 48) mem48[a] = d;
    else err48_m = 1'b1;
    check_err();
    @(negedge clk);
    check("wr_ack_pulse", wr_ack, 0);
  endtask

  // Write and read raised together: write first, read after IDLE.
  task automatic do_both(input int wa, input logic d, input int ra);
    int lat;
    wr_addr = 6'(wa); wr_data = d; wr_req = 1'b1;
    rd_addr = 6'(ra); rd_req = 1'b1;
    wait_ack(1'b0, lat);
    wr_req = 1'b0;
    check("both_wr_latency", lat, 1);
    mem64[wa] = d;
    if (wa < 48) mem48[wa] = d;
    else err48_m = 1'b1;
    wait_ack(1'b1, lat);
    rd_req = 1'b0;
    if (ra >= 48) err48_m = 1'b1;
    check("both_rd_latency", lat, 6);
    check_window(ra);
    check_err();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 1'b0;
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = 1'b0;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_rd_ack", rd_ack, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_busy48", busy_b, 0);
    check("rst_window", rd_window, 0);
    check_err();

    // row preload: fixed head and tail, random middle
    for (int i = 0; i < 64; i++) begin
      logic d;
      case (i)
        0, 2, 3, 5: d = 1'b1;
        1, 4:       d = 1'b0;
        62:         d = 1'b0;
        63:         d = 1'b1;
        default:    d = 1'($urandom_range(0, 1));
      endcase
      do_load(i, d);
    end

    // reset clears err, keeps RAM
    do_reset();
    check_err();

    do_read(2);
    check("win_a2_const", rd_window, 3'b011);
    do_read(0);
    check("win_a0_const", rd_window, 3'b110);
    do_read(63);
    check("win_a63_const", rd_window, 3'b011);

    // out-of-range read on the 48-deep row
    do_read(50);
    check("oor_window48", rd_window_b, 3'b000);
    check("oor_err48", err_b, 1);
    do_read(10);
    check("err48_sticky", err_b, 1);

    // write-back then read
    do_write(4, 1'b1);
    do_read(4);
    check("centre_after_wr", 32'(rd_window[1]), 1);

    // simultaneous write and read
    do_both(4, 1'b0, 4);
    check("centre_after_both", 32'(rd_window[1]), 0);

    // load while busy is ignored
    begin
      int lat;
      rd_addr = 6'd2; rd_req = 1'b1;
      @(negedge clk);
      ld_addr = 6'd5; ld_data = ~mem64[5]; ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      wait_ack(1'b1, lat);
      rd_req = 1'b0;
      check_window(2);
      check_err();
      @(negedge clk);
      do_read(5);
    end

    // reset during F2 aborts the read
    rd_addr = 6'd2; rd_req = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_in_f2", busy, 1);
    rst = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    err64_m = 1'b0; err48_m = 1'b0; win64_m = 3'b000; win48_m = 3'b000;
    check("abort_busy", busy, 0);
    check("abort_rd_ack", rd_ack, 0);
    check("abort_window", rd_window, 0);
    check_err();
    do_read(2);
    check("reread_a2", rd_window, 3'b011);

    // reset at the commit edge of a write drops the write
    wr_addr = 6'd7; wr_data = ~mem64[7]; wr_req = 1'b1;
    @(negedge clk);
    check("wr_ack_before_rst", wr_ack, 1);
    rst = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    err64_m = 1'b0; err48_m = 1'b0; win64_m = 3'b000; win48_m = 3'b000;
    check("wr_abort_busy", busy, 0);
    do_read(7);

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      int op, a1, a2;
      logic d;
      op = $urandom_range(0, 3);
      a1 = $urandom_range(0, 63);
      a2 = $urandom_range(0, 63);
      d  = 1'($urandom_range(0, 1));
      case (op)
        0: do_load(a1, d);
        1: do_write(a1, d);
        2: do_read(a1);
        default: do_both(a1, d, a2);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
